// File: rtl/max_unpooling_unit_pkg.sv
// Shared definitions for the max-unpooling datapath.
// Data width, signed element type and FSM state encoding.
package max_unpooling_unit_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_e;

endpackage

// File: rtl/max_unpooling_unit_index_fifo.sv
// Circular FIFO holding argmax indices from the forward pass.
// Ready is based on registered occupancy only; no bypass path.
module max_unpooling_unit_index_fifo #(
    parameter  int DEPTH = 16,
    parameter  int IW    = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [IW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          pop_valid_o,
    output logic [IW-1:0] pop_data_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign push_ready_o = (count_q < FULL);
    assign pop_valid_o  = (count_q != '0);
    assign pop_data_o   = mem_q[rptr_q];
    assign count_o      = count_q;
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && pop_valid_o;

    // Pointer and occupancy next-state; pointers wrap at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/max_unpooling_unit.sv
// Max-unpooling: routes each pooled value to its argmax slot,
// zero-filling the rest, one element per beat.
module max_unpooling_unit
    import max_unpooling_unit_pkg::*;
#(
    parameter  int SIZE  = 4,
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(SIZE),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     idx_valid,
    output logic                     idx_ready,
    input  logic [IW-1:0]            idx_in,
    input  logic                     grad_valid,
    output logic                     grad_ready,
    input  logic signed [DATA_W-1:0] grad_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic [CW-1:0]            count,
    output logic                     idx_error
);

    localparam logic [IW-1:0] K_LAST = IW'(SIZE - 1);
    localparam logic [IW:0]   SIZE_W = (IW + 1)'(SIZE);

    state_e        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] idx_q, idx_d;
    data_t         val_q, val_d;
    logic          err_q, err_d;
    logic          fifo_valid;
    logic [IW-1:0] fifo_head;
    logic          accept;

    max_unpooling_unit_index_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (idx_valid),
        .push_ready_o (idx_ready),
        .push_data_i  (idx_in),
        .pop_i        (accept),
        .pop_valid_o  (fifo_valid),
        .pop_data_o   (fifo_head),
        .count_o      (count)
    );

    assign idx_error = err_q;

    // FSM next state, element counter and output mux.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        val_d      = val_q;
        err_d      = err_q;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_last  = (k_q == K_LAST);
                out_data  = (k_q == idx_q) ? val_q : '0;
                if (out_ready) begin
                    if (k_q == K_LAST) state_d = ST_IDLE;
                    else               k_d     = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new window may start only once the previous one completes.
        grad_ready = fifo_valid &&
                     ((state_q == ST_IDLE) || (out_last && out_ready));
        accept = grad_valid && grad_ready;
        if (accept) begin
            state_d = ST_EMIT;
            k_d     = '0;
            idx_d   = fifo_head;
            val_d   = grad_in;
            if ({1'b0, fifo_head} >= SIZE_W) err_d = 1'b1;
        end
    end

    // FSM and window registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_max_unpooling_unit.sv
// Self-checking bench for max_unpooling_unit (SIZE=4 and SIZE=3).
// Queue-based reference model of index FIFO and pending beats.
module tb_max_unpooling_unit;

    localparam int SIZE  = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        idx_valid, idx_ready, grad_valid, grad_ready;
    logic [1:0]  idx_in;
    logic signed [15:0] grad_in, out_data;
    logic        out_valid, out_ready, out_last, idx_error;
    logic [4:0]  count;

    logic        s3_idx_valid, s3_idx_ready, s3_grad_valid, s3_grad_ready;
    logic [1:0]  s3_idx_in;
    logic signed [15:0] s3_grad_in, s3_out_data;
    logic        s3_out_valid, s3_out_ready, s3_out_last, s3_idx_error;
    logic [4:0]  s3_count;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          fifo_q[$];
    beat_t       beats[$];
    logic [15:0] got[$];
    logic [25:0] obs, expv;
    logic        o_v, o_ir;
    logic [4:0]  o_c;

    always #5 clk = ~clk;

    max_unpooling_unit #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx_in     (idx_in),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_in    (grad_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .count      (count),
        .idx_error  (idx_error)
    );

    max_unpooling_unit #(.SIZE(3), .DEPTH(16)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .idx_valid  (s3_idx_valid),
        .idx_ready  (s3_idx_ready),
        .idx_in     (s3_idx_in),
        .grad_valid (s3_grad_valid),
        .grad_ready (s3_grad_ready),
        .grad_in    (s3_grad_in),
        .out_valid  (s3_out_valid),
        .out_ready  (s3_out_ready),
        .out_data   (s3_out_data),
        .out_last   (s3_out_last),
        .count      (s3_count),
        .idx_error  (s3_idx_error)
    );

    // One cycle: drive at negedge, sample, predict, advance model.
    task automatic step(input logic iv, input logic [1:0] ii,
                        input logic gv, input logic [15:0] gd,
                        input logic orr);
        beat_t b;
        int    w;
        logic  e_v, e_l, e_ir, e_gr;
        logic [15:0] e_d;
        @(negedge clk);
        idx_valid  = iv;
        idx_in     = ii;
        grad_valid = gv;
        grad_in    = gd;
        out_ready  = orr;
        #1;
        e_v  = (beats.size() != 0);
        e_d  = e_v ? beats[0].d : 16'h0;
        e_l  = e_v ? beats[0].l : 1'b0;
        e_ir = (fifo_q.size() < DEPTH);
        e_gr = (fifo_q.size() != 0) &&
               (beats.size() == 0 || (beats.size() == 1 && orr));
        expv = {e_v, e_d, e_l, 5'(fifo_q.size()), e_ir, e_gr, 1'b0};
        obs  = {out_valid, out_data, out_last, count,
                idx_ready, grad_ready, idx_error};
        o_v  = out_valid;
        o_c  = count;
        o_ir = idx_ready;
        if (out_valid && orr) got.push_back(out_data);
        if (e_v && orr) void'(beats.pop_front());
        if (gv && e_gr) begin
            w = fifo_q.pop_front();
            for (int k = 0; k < SIZE; k++) begin
                b.d = (k == w) ? gd : 16'h0;
                b.l = (k == SIZE - 1);
                beats.push_back(b);
            end
        end
        if (iv && e_ir) fifo_q.push_back(int'(ii));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() == 0 && beats.size() == 0) break;
            step(1'b0, 2'd0, 1'b1, 16'($urandom), 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL %s_drain: got %h want %h", name, obs, expv);
            end
        end
        n_tests++;
        if (fifo_q.size() != 0 || beats.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: left %0d idx %0d beats want 0",
                     name, fifo_q.size(), beats.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_data, out_last, idx_ready, grad_ready,
             count, idx_error} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b0,
             5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got v%b d%h l%b ir%b gr%b c%0d e%b",
                     out_valid, out_data, out_last, idx_ready,
                     grad_ready, count, idx_error);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'd0, 1'b1, 16'h1234, 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_idle: got %h want %h", obs, expv);
            end
        end
    endtask

    task automatic test_single;
        logic [15:0] ex [4];
        ex = '{16'h0, 16'h0, 16'h0123, 16'h0};
        got.delete();
        step(1'b1, 2'd2, 1'b0, 16'h0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 16'h0123, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single_c%0d: got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL single_len: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got[i] !== ex[i]) begin
                    n_fail++;
                    $display("FAIL single_b%0d: got %h want %h",
                             i, got[i], ex[i]);
                end
            end
        end
    endtask

    task automatic test_sign;
        got.delete();
        step(1'b1, 2'd0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 16'hFFFB, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL sign_c%0d: got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (got.size() != 4 || got[0] !== 16'hFFFB) begin
            n_fail++;
            $display("FAIL sign_b0: got n%0d first %h want 4 fffb",
                     got.size(), got.size() ? got[0] : 16'hx);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ex [8];
        ex = '{16'h0, 16'h7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h9};
        got.delete();
        step(1'b1, 2'd1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 2'd3, 1'b0, 16'h0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 16'h7, 1'b1);
        n_tests++;
        if (o_c !== 5'd2) begin
            n_fail++;
            $display("FAIL b2b_count2: got %0d want 2", o_c);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'd0, 1'b1, 16'h9, 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_len: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (got[i] !== ex[i]) begin
                    n_fail++;
                    $display("FAIL b2b_b%0d: got %h want %h",
                             i, got[i], ex[i]);
                end
            end
        end
        drain("b2b");
    endtask

    task automatic test_backpressure;
        logic [7:0] rdy;
        rdy = 8'b1110_0011;
        got.delete();
        step(1'b1, 2'd2, 1'b0, 16'h0, 1'b1);
        step(1'b0, 2'd0, 1'b1, 16'h55AA, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'd0, 1'b0, 16'h0, rdy[i]);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bp_c%0d: got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (got.size() != 4 || got[2] !== 16'h55AA) begin
            n_fail++;
            $display("FAIL bp_seq: got n%0d want 4 with 55aa at 2",
                     got.size());
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b1);
        step(1'b1, 2'd1, 1'b0, 16'h0, 1'b1);
        n_tests++;
        if (o_c !== 5'd16 || o_ir !== 1'b0 || obs !== expv) begin
            n_fail++;
            $display("FAIL full: got c%0d ir%b %h want c16 ir0 %h",
                     o_c, o_ir, obs, expv);
        end
        step(1'b1, 2'd1, 1'b1, 16'h4242, 1'b1);
        n_tests++;
        if (o_c !== 5'd16 || o_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL full_held: got c%0d ir%b want c16 ir0", o_c, o_ir);
        end
        step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
        n_tests++;
        if (o_c !== 5'd15 || o_ir !== 1'b1 || obs !== expv) begin
            n_fail++;
            $display("FAIL full_pop: got c%0d ir%b want c15 ir1", o_c, o_ir);
        end
        drain("full");
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom),
                 ($urandom_range(0, 3) != 0));
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h want %h", i, obs, expv);
            end
        end
        drain("random");
    endtask

    task automatic test_size3;
        @(negedge clk);
        s3_idx_valid = 1'b1;
        s3_idx_in    = 2'd3;
        s3_out_ready = 1'b1;
        @(negedge clk);
        s3_idx_valid  = 1'b0;
        s3_grad_valid = 1'b1;
        s3_grad_in    = 16'h7777;
        #1;
        n_tests++;
        if (s3_grad_ready !== 1'b1 || s3_idx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_accept: got gr%b e%b want gr1 e0",
                     s3_grad_ready, s3_idx_error);
        end
        @(negedge clk);
        s3_grad_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({s3_out_valid, s3_out_data, s3_out_last} !==
                {1'b1, 16'h0, (i == 2)}) begin
                n_fail++;
                $display("FAIL s3_b%0d: got v%b d%h l%b want v1 d0 l%0d",
                         i, s3_out_valid, s3_out_data, s3_out_last, i == 2);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (s3_out_valid !== 1'b0 || s3_idx_error !== 1'b1) begin
            n_fail++;
            $display("FAIL s3_err: got v%b e%b want v0 e1",
                     s3_out_valid, s3_idx_error);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 2'd1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 16'h0, 1'b1);
        step(1'b1, 2'd3, 1'b1, 16'h1111, 1'b1);
        step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
        n_tests++;
        if (o_v !== 1'b1 || obs !== expv) begin
            n_fail++;
            $display("FAIL rmid_pre: got %h want %h", obs, expv);
        end
        @(negedge clk);
        reset      = 1'b1;
        idx_valid  = 1'b0;
        grad_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_data, out_last, count, idx_ready, grad_ready,
             idx_error, s3_idx_error} !== {1'b0, 16'h0, 1'b0, 5'd0,
             1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid: got v%b d%h l%b c%0d ir%b gr%b e%b e3%b",
                     out_valid, out_data, out_last, count, idx_ready,
                     grad_ready, idx_error, s3_idx_error);
        end
        reset = 1'b0;
        fifo_q.delete();
        beats.delete();
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rmid_post_c%0d: got %h want %h", i, obs, expv);
            end
        end
        drain("rmid");
    endtask

    initial begin
        reset         = 1'b1;
        idx_valid     = 1'b0;
        idx_in        = 2'd0;
        grad_valid    = 1'b0;
        grad_in       = 16'h0;
        out_ready     = 1'b0;
        s3_idx_valid  = 1'b0;
        s3_idx_in     = 2'd0;
        s3_grad_valid = 1'b0;
        s3_grad_in    = 16'h0;
        s3_out_ready  = 1'b1;
        test_reset();
        test_single();
        test_sign();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_random();
        test_size3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
